// File: rtl/gear_input_conditioner.sv
// Button conditioner in front of the gearbox FSM: synchronise and debounce each button,
// then turn every accepted up/down press into one request held for a full slow-clock period.
module gear_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_brake,
    output logic shift_up,
    output logic shift_down,
    output logic brake,
    output logic busy
);

    localparam int unsigned NCH      = 3;
    localparam int unsigned CH_UP    = 0;
    localparam int unsigned CH_DOWN  = 1;
    localparam int unsigned CH_BRAKE = 2;
    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W   = $clog2(HOLD_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_UP   = 2'd1,
        HOLD_DOWN = 2'd2
    } state_t;

    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] w_stable;
    logic [NCH-1:0] w_rise;

    assign w_raw = {btn_brake, btn_down, btn_up};

    // Per-channel two-flop synchroniser, debouncer and edge detector
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic            r_sync1;
        logic            r_sync2;
        logic            r_stable;
        logic            r_stable_d;
        logic [DB_W-1:0] r_db_cnt;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_sync1    <= 1'b0;
                r_sync2    <= 1'b0;
                r_stable   <= 1'b0;
                r_stable_d <= 1'b0;
                r_db_cnt   <= '0;
            end else begin
                r_sync1    <= w_raw[g];
                r_sync2    <= r_sync1;
                r_stable_d <= r_stable;
                if (r_sync2 != r_stable) begin
                    if (r_db_cnt == DB_LAST) begin
                        r_stable <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end else begin
                    r_db_cnt <= '0;
                end
            end
        end

        assign w_stable[g] = r_stable;
        assign w_rise[g]   = r_stable & ~r_stable_d;
    end

    state_t              r_state;
    state_t              w_state_next;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_cnt_next;
    logic                r_shift_up;
    logic                r_shift_down;
    logic                r_brake;
    logic                r_busy;

    // State register; outputs registered from the next-state decode
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_hold_cnt   <= '0;
            r_shift_up   <= 1'b0;
            r_shift_down <= 1'b0;
            r_brake      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_hold_cnt   <= w_hold_cnt_next;
            r_shift_up   <= (w_state_next == HOLD_UP);
            r_shift_down <= (w_state_next == HOLD_DOWN);
            r_brake      <= w_stable[CH_BRAKE];
            r_busy       <= (w_state_next != IDLE);
        end
    end

    // Next-state: a brake level blocks new requests and aborts an active hold
    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        unique case (r_state)
            IDLE: begin
                if (!w_stable[CH_BRAKE]) begin
                    if (w_rise[CH_UP] && !w_rise[CH_DOWN]) begin
                        w_state_next    = HOLD_UP;
                        w_hold_cnt_next = '0;
                    end else if (w_rise[CH_DOWN] && !w_rise[CH_UP]) begin
                        w_state_next    = HOLD_DOWN;
                        w_hold_cnt_next = '0;
                    end
                end
            end
            HOLD_UP, HOLD_DOWN: begin
                if (w_stable[CH_BRAKE] || (r_hold_cnt == HOLD_LAST)) begin
                    w_state_next    = IDLE;
                    w_hold_cnt_next = '0;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_hold_cnt_next = '0;
            end
        endcase
    end

    assign shift_up   = r_shift_up;
    assign shift_down = r_shift_down;
    assign brake      = r_brake;
    assign busy       = r_busy;

endmodule

// File: tb/tb_gear_input_conditioner.sv
// Directed bench for gear_input_conditioner with short debounce/hold constants;
// observed vector is {shift_up, shift_down, brake, busy}, sampled 1 ns after each rising edge.
module tb_gear_input_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned HC = 8;

    logic clk       = 1'b0;
    logic reset     = 1'b0;
    logic btn_up    = 1'b0;
    logic btn_down  = 1'b0;
    logic btn_brake = 1'b0;
    logic shift_up;
    logic shift_down;
    logic brake;
    logic busy;
    logic [3:0] obs;
    logic [3:0] exp_v;

    int n_checks = 0;
    int n_errors = 0;

    gear_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_brake (btn_brake),
        .shift_up  (shift_up),
        .shift_down(shift_down),
        .brake     (brake),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign obs = {shift_up, shift_down, brake, busy};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset
        step(3);
        check("rst_active", 32'(obs), 32'h0);
        reset = 1'b1;
        step(2);
        check("rst_release", 32'(obs), 32'h0);

        // 2: clean held up press -> high edges 7..14, no second pulse
        btn_up = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            step(1);
            exp_v = (k >= 7 && k <= 14) ? 4'b1001 : 4'b0000;
            check($sformatf("up_e%0d", k), 32'(obs), 32'(exp_v));
        end
        btn_up = 1'b0;
        step(10);
        check("up_release", 32'(obs), 32'h0);

        // 3: bouncing down button never accepted
        for (int i = 0; i < 6; i++) begin
            btn_down = (i < 4) ? ((i % 2) == 0) : 1'b0;
            for (int j = 0; j < 2; j++) begin
                step(1);
                check($sformatf("bounce_sd_%0d_%0d", i, j), 32'(shift_down), 32'h0);
                check($sformatf("bounce_cnt_%0d_%0d", i, j),
                      32'(dut.g_ch[1].r_db_cnt != 2'd3), 32'h1);
            end
        end
        step(6);
        check("bounce_idle", 32'(obs), 32'h0);

        // 4: brake held blocks up press
        btn_brake = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_v = (k >= 7) ? 4'b0010 : 4'b0000;
            check($sformatf("brk_e%0d", k), 32'(obs), 32'(exp_v));
        end
        btn_up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check($sformatf("brk_up_e%0d", k), 32'(obs), 32'h2);
        end
        btn_up    = 1'b0;
        btn_brake = 1'b0;
        step(10);
        check("brk_release", 32'(obs), 32'h0);

        // 5: brake aborts hold at hold_cnt 3
        btn_up = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            if (k == 4) btn_brake = 1'b1;
            if (k < 7)       exp_v = 4'b0000;
            else if (k < 11) exp_v = 4'b1001;
            else             exp_v = 4'b0010;
            check($sformatf("abort_e%0d", k), 32'(obs), 32'(exp_v));
            if (k == 10) check("abort_hold_cnt", 32'(dut.r_hold_cnt), 32'd3);
        end
        btn_up    = 1'b0;
        btn_brake = 1'b0;
        step(10);
        check("abort_release", 32'(obs), 32'h0);

        // 6a: simultaneous up and down ignored
        btn_up   = 1'b1;
        btn_down = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            check($sformatf("both_e%0d", k), 32'(obs), 32'h0);
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        step(10);
        check("both_release", 32'(obs), 32'h0);

        // 6b: down press during HOLD_UP is dropped
        btn_up = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            if (k == 2) btn_down = 1'b1;
            exp_v = (k >= 7 && k <= 14) ? 4'b1001 : 4'b0000;
            check($sformatf("drop_e%0d", k), 32'(obs), 32'(exp_v));
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        step(10);
        check("drop_release", 32'(obs), 32'h0);

        // Reset mid-hold drops the request on that edge
        btn_up = 1'b1;
        step(9);
        check("midrst_hold", 32'(obs), 32'h9);
        reset  = 1'b0;
        btn_up = 1'b0;
        step(1);
        check("midrst_drop", 32'(obs), 32'h0);
        step(2);
        reset = 1'b1;
        step(12);
        check("midrst_after", 32'(obs), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
